// File: rtl/systolic_array_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_STREAM,
        ST_DONE
    } ctrl_state_e;

    localparam int K_MAX_DEFAULT = 16;

    // Skew depth of an M x N array: the last operand needs M+N cycles to reach the far corner.
    function automatic int drain_cycles(input int m_rows, input int n_cols);
        return m_rows + n_cols;
    endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Job, operand-buffer, array-control and stream-out signals of the sequencer.
interface systolic_array_ctrl_if
    import systolic_ctrl_pkg::*;
#(
    parameter int K_MAX  = K_MAX_DEFAULT,
    parameter int K_W    = $clog2(K_MAX + 1),
    parameter int ADDR_W = $clog2(K_MAX)
);

    logic              start_i;
    logic [K_W-1:0]    k_dim_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              a_rd_en_o;
    logic [ADDR_W-1:0] a_rd_addr_o;
    logic              b_rd_en_o;
    logic [ADDR_W-1:0] b_rd_addr_o;
    logic              feed_a_valid_o;
    logic              feed_b_valid_o;
    logic              a_clr_o;
    logic              b_clr_o;
    logic              acc_clr_o;
    logic              start_stream_o;
    logic              stream_clr_o;
    logic              stream_valid_i;

    modport master (
        output start_i, k_dim_i, abort_i, stream_valid_i,
        input  busy_o, done_o, err_o,
        input  a_rd_en_o, a_rd_addr_o, b_rd_en_o, b_rd_addr_o,
        input  feed_a_valid_o, feed_b_valid_o,
        input  a_clr_o, b_clr_o, acc_clr_o, start_stream_o, stream_clr_o
    );

    modport slave (
        input  start_i, k_dim_i, abort_i, stream_valid_i,
        output busy_o, done_o, err_o,
        output a_rd_en_o, a_rd_addr_o, b_rd_en_o, b_rd_addr_o,
        output feed_a_valid_o, feed_b_valid_o,
        output a_clr_o, b_clr_o, acc_clr_o, start_stream_o, stream_clr_o
    );

endinterface

// File: rtl/systolic_array_ctrl_counter.sv
// Loadable up-counter with clear, enable and terminal-count compare.
module ctrl_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Clear wins over load, load wins over count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == term_val);

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the systolic MAC array: clear, feed K operand vectors, drain, stream out.
module systolic_array_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int M_ROWS       = 4,
    parameter int N_COLS       = 4,
    parameter int K_MAX        = K_MAX_DEFAULT,
    parameter int K_W          = $clog2(K_MAX + 1),
    parameter int ADDR_W       = $clog2(K_MAX),
    parameter int DRAIN_CYCLES = drain_cycles(M_ROWS, N_COLS)
) (
    input logic                 clk_i,
    input logic                 rst_i,
    systolic_array_ctrl_if.slave bus
);

    localparam int TOTAL_ELEM = M_ROWS * N_COLS;
    localparam int BEAT_W     = $clog2(TOTAL_ELEM + 1);
    localparam int DRAIN_W    = $clog2(DRAIN_CYCLES + 1);

    ctrl_state_e        state_q;
    ctrl_state_e        state_d;
    logic [K_W-1:0]     k_q;
    logic               k_ok;
    logic               start_ok;
    logic               job_abort;

    logic               rd_en;
    logic               clr_all;
    logic               done;
    logic               busy;
    logic               err_q;
    logic               abort_clr_q;
    logic               strm_entry_q;
    logic               feed_vld_p1;

    logic               feed_en, feed_clr, feed_tc;
    logic [ADDR_W-1:0]  feed_cnt, feed_term;
    logic               drain_en, drain_clr, drain_tc;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               beat_en, beat_clr, beat_tc, beat_done;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               unused_cnt;

    assign k_ok      = (bus.k_dim_i != '0) && (bus.k_dim_i <= K_W'(K_MAX));
    assign start_ok  = (state_q == ST_IDLE) && bus.start_i && k_ok;
    assign job_abort = bus.abort_i && (state_q != ST_IDLE);

    assign feed_term = ADDR_W'(k_q - K_W'(1));
    assign feed_en   = (state_q == ST_FEED);
    assign feed_clr  = job_abort || !feed_en || feed_tc;

    assign drain_en  = (state_q == ST_DRAIN);
    assign drain_clr = job_abort || !drain_en || drain_tc;

    // Only beats seen while streaming count; stray valids elsewhere never move the counter.
    assign beat_en   = (state_q == ST_STREAM) && bus.stream_valid_i;
    assign beat_done = beat_en && beat_tc;
    assign beat_clr  = job_abort || (state_q != ST_STREAM) || beat_done;

    ctrl_counter #(.W(ADDR_W)) u_feed_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (feed_clr),
        .en       (feed_en),
        .load     (1'b0),
        .load_val ('0),
        .term_val (feed_term),
        .cnt      (feed_cnt),
        .tc       (feed_tc)
    );

    ctrl_counter #(.W(DRAIN_W)) u_drain_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (drain_clr),
        .en       (drain_en),
        .load     (1'b0),
        .load_val ('0),
        .term_val (DRAIN_W'(DRAIN_CYCLES - 1)),
        .cnt      (drain_cnt),
        .tc       (drain_tc)
    );

    ctrl_counter #(.W(BEAT_W)) u_beat_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (beat_clr),
        .en       (beat_en),
        .load     (1'b0),
        .load_val ('0),
        .term_val (BEAT_W'(TOTAL_ELEM - 1)),
        .cnt      (beat_cnt),
        .tc       (beat_tc)
    );

    assign unused_cnt = ^{drain_cnt, beat_cnt};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            err_q        <= 1'b0;
            abort_clr_q  <= 1'b0;
            strm_entry_q <= 1'b0;
            feed_vld_p1  <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (start_ok) begin
                k_q <= bus.k_dim_i;
            end
            err_q        <= (state_q == ST_IDLE) && bus.start_i && !k_ok;
            abort_clr_q  <= job_abort;
            strm_entry_q <= drain_en && drain_tc && !job_abort;
            // p1: operand buffer read data lands one cycle after rd_en
            feed_vld_p1  <= rd_en && !job_abort;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        clr_all = abort_clr_q;
        done    = 1'b0;
        busy    = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_all = 1'b1;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                rd_en = 1'b1;
                if (feed_tc) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_tc) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (beat_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (job_abort) state_d = ST_IDLE;
    end

    assign bus.busy_o         = busy;
    assign bus.done_o         = done;
    assign bus.err_o          = err_q;
    assign bus.a_rd_en_o      = rd_en;
    assign bus.b_rd_en_o      = rd_en;
    assign bus.a_rd_addr_o    = rd_en ? feed_cnt : '0;
    assign bus.b_rd_addr_o    = rd_en ? feed_cnt : '0;
    assign bus.feed_a_valid_o = feed_vld_p1;
    assign bus.feed_b_valid_o = feed_vld_p1;
    assign bus.a_clr_o        = clr_all;
    assign bus.b_clr_o        = clr_all;
    assign bus.acc_clr_o      = clr_all;
    assign bus.stream_clr_o   = clr_all;
    assign bus.start_stream_o = strm_entry_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl: stimulus queues expected event cycles, a negedge monitor pops and compares.
module tb_systolic_array_ctrl;

    localparam int K_W    = 5;
    localparam int ADDR_W = 4;
    localparam int DRAIN  = 8;
    localparam int TOTAL  = 16;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int q_addr_cyc[$];
    int q_addr_val[$];
    int q_vld[$];
    int q_strm[$];
    int q_done[$];
    int q_err[$];
    int q_clr[$];

    int gaps[16] = '{0, 2, 1, 3, 0, 0, 1, 2, 3, 0, 1, 0, 2, 3, 1, 0};

    systolic_array_ctrl_if #(.K_MAX(16)) bus ();

    systolic_array_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int out_vec();
        return int'({bus.busy_o, bus.done_o, bus.err_o, bus.a_rd_en_o, bus.a_rd_addr_o,
                     bus.b_rd_en_o, bus.b_rd_addr_o, bus.feed_a_valid_o, bus.feed_b_valid_o,
                     bus.a_clr_o, bus.b_clr_o, bus.acc_clr_o, bus.start_stream_o, bus.stream_clr_o});
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        int v;
        logic [ADDR_W-1:0] ea;
        if (bus.a_rd_en_o === 1'b1 || bus.b_rd_en_o === 1'b1) begin
            if (q_addr_cyc.size() == 0) begin
                chk("rd_en_unexpected", cyc, -1);
            end else begin
                chk("rd_cycle", cyc, q_addr_cyc.pop_front());
                v  = q_addr_val.pop_front();
                ea = ADDR_W'(v);
                chk("rd_addr", int'({bus.a_rd_en_o, bus.b_rd_en_o, bus.a_rd_addr_o, bus.b_rd_addr_o}),
                    int'({2'b11, ea, ea}));
            end
        end
        if (bus.feed_a_valid_o === 1'b1 || bus.feed_b_valid_o === 1'b1) begin
            if (q_vld.size() == 0) chk("feed_vld_unexpected", cyc, -1);
            else begin
                chk("feed_vld_cycle", cyc, q_vld.pop_front());
                chk("feed_vld_pair", int'({bus.feed_a_valid_o, bus.feed_b_valid_o}), 3);
            end
        end
        if (bus.a_clr_o === 1'b1 || bus.b_clr_o === 1'b1 || bus.acc_clr_o === 1'b1 || bus.stream_clr_o === 1'b1) begin
            if (q_clr.size() == 0) chk("clr_unexpected", cyc, -1);
            else begin
                chk("clr_cycle", cyc, q_clr.pop_front());
                chk("clr_all_four", int'({bus.a_clr_o, bus.b_clr_o, bus.acc_clr_o, bus.stream_clr_o}), 15);
            end
        end
        if (bus.start_stream_o === 1'b1) begin
            if (q_strm.size() == 0) chk("start_stream_unexpected", cyc, -1);
            else chk("start_stream_cycle", cyc, q_strm.pop_front());
        end
        if (bus.done_o === 1'b1) begin
            if (q_done.size() == 0) chk("done_unexpected", cyc, -1);
            else chk("done_cycle", cyc, q_done.pop_front());
        end
        if (bus.err_o === 1'b1) begin
            if (q_err.size() == 0) chk("err_unexpected", cyc, -1);
            else chk("err_cycle", cyc, q_err.pop_front());
        end
    end

    task automatic run_job(input int k, input bit gappy, input bit poke, input bit do_rst, input bit abort_too);
        int c0, ent, last;
        c0 = cyc;
        bus.start_i        = 1'b1;
        bus.k_dim_i        = K_W'(k);
        bus.abort_i        = abort_too;
        bus.stream_valid_i = !gappy;
        q_clr.push_back(c0 + 1);
        for (int i = 0; i < k; i++) begin
            q_addr_cyc.push_back(c0 + 2 + i);
            q_addr_val.push_back(i);
            q_vld.push_back(c0 + 3 + i);
        end
        ent = c0 + 2 + k + DRAIN;
        q_strm.push_back(ent);
        next_cyc();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("busy_in_job", int'(bus.busy_o), 1);
        if (gappy) begin
            while (cyc < ent) begin
                bus.stream_valid_i = cyc[0];
                next_cyc();
            end
            last = ent;
            for (int b = 0; b < TOTAL; b++) begin
                bus.stream_valid_i = 1'b0;
                repeat (gaps[b]) next_cyc();
                bus.stream_valid_i = 1'b1;
                if (b == TOTAL - 1) begin
                    last = cyc;
                    q_done.push_back(last + 1);
                end
                next_cyc();
            end
        end else begin
            if (poke) begin
                while (cyc < c0 + k + 5) next_cyc();
                bus.start_i = 1'b1;
                bus.k_dim_i = K_W'(5);
                next_cyc();
                bus.start_i = 1'b0;
            end
            if (do_rst) begin
                while (cyc < ent + 3) next_cyc();
                rst = 1'b1;
                next_cyc();
                rst = 1'b0;
                chk("rst_mid_stream_outputs", out_vec(), 0);
                bus.stream_valid_i = 1'b0;
                next_cyc();
                chk("rst_mid_stream_idle", int'(bus.busy_o), 0);
                return;
            end
            last = ent + TOTAL - 1;
            q_done.push_back(last + 1);
            while (cyc < last + 1) next_cyc();
        end
        chk("busy_at_done", int'(bus.busy_o), 1);
        next_cyc();
        chk("busy_after_done", int'(bus.busy_o), 0);
        repeat (2) next_cyc();
        bus.stream_valid_i = 1'b0;
        next_cyc();
    endtask

    task automatic bad_start(input int k);
        int c0;
        c0 = cyc;
        bus.start_i = 1'b1;
        bus.k_dim_i = K_W'(k);
        q_err.push_back(c0 + 1);
        next_cyc();
        bus.start_i = 1'b0;
        chk("err_busy_low", int'(bus.busy_o), 0);
        next_cyc();
        chk("err_busy_still_low", int'(bus.busy_o), 0);
    endtask

    task automatic abort_job();
        int c0;
        c0 = cyc;
        bus.start_i = 1'b1;
        bus.k_dim_i = K_W'(4);
        q_clr.push_back(c0 + 1);
        q_clr.push_back(c0 + 5);
        for (int i = 0; i < 3; i++) begin
            q_addr_cyc.push_back(c0 + 2 + i);
            q_addr_val.push_back(i);
        end
        q_vld.push_back(c0 + 3);
        q_vld.push_back(c0 + 4);
        next_cyc();
        bus.start_i = 1'b0;
        while (cyc < c0 + 4) next_cyc();
        bus.abort_i = 1'b1;
        next_cyc();
        bus.abort_i = 1'b0;
        chk("abort_busy", int'(bus.busy_o), 0);
        chk("abort_rd_en", int'(bus.a_rd_en_o), 0);
        next_cyc();
        chk("abort_settled_outputs", out_vec(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.start_i        = 1'b0;
        bus.k_dim_i        = '0;
        bus.abort_i        = 1'b0;
        bus.stream_valid_i = 1'b0;
        repeat (2) next_cyc();
        chk("reset_outputs", out_vec(), 0);
        rst = 1'b0;
        next_cyc();

        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(16, 1'b0, 1'b0, 1'b0, 1'b0);
        bad_start(0);
        bad_start(17);
        run_job(4, 1'b1, 1'b0, 1'b0, 1'b0);
        abort_job();
        bus.abort_i = 1'b1;
        repeat (2) next_cyc();
        bus.abort_i = 1'b0;
        chk("abort_in_idle_busy", int'(bus.busy_o), 0);
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b1);
        run_job(3, 1'b0, 1'b1, 1'b0, 1'b0);
        run_job(2, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) next_cyc();

        chk("addr_events_missing", q_addr_cyc.size(), 0);
        chk("vld_events_missing", q_vld.size(), 0);
        chk("clr_events_missing", q_clr.size(), 0);
        chk("strm_events_missing", q_strm.size(), 0);
        chk("done_events_missing", q_done.size(), 0);
        chk("err_events_missing", q_err.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
